// File: rtl/text_pkg.sv
// Shared constants and state types for the text page streamer.
package text_pkg;
  localparam int ROM_AW = 5;
  localparam int CHAR_W = 7;
  localparam logic [CHAR_W-1:0] ASCII_SP = 7'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {IDLE, SCAN, EMIT, CR, LF, DONE} state_t;
  typedef enum logic [1:0] {PH_ADDR, PH_LOAD, PH_WAIT} phase_t;
endpackage

// File: rtl/text_page_streamer_if.sv
// Byte link from the page streamer to the serial transmitter.
interface text_page_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/text_page_streamer_tx_byte_holder.sv
// Single-entry valid/ready output register; a load may replace a byte in its handshake cycle.
module text_page_streamer_tx_byte_holder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       flush,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/text_page_streamer.sv
// Walks the text ROM row by row and streams each (optionally trimmed) row plus CR LF.
// States: IDLE wait start | SCAN find last non-space | EMIT send chars | CR | LF | DONE pulse
module text_page_streamer
  import text_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int TRIM = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ROM_AW-1:0]     rom_row,
  output logic [ROM_AW-1:0]     rom_col,
  input  logic [CHAR_W-1:0]     rom_digit,
  text_page_streamer_if.master  tx,
  output logic                  busy,
  output logic                  done
);
  localparam logic [ROM_AW-1:0] ROW_LAST = ROM_AW'(ROWS - 1);
  localparam logic [ROM_AW-1:0] COL_LAST = ROM_AW'(COLS - 1);

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [ROM_AW-1:0] row_q, row_d, col_q, col_d, last_q, last_d;
  logic              load, flush, hs, valid_w;
  logic [7:0]        load_data, data_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_ADDR;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    row_d     = row_q;
    col_d     = col_q;
    last_d    = last_q;
    load      = 1'b0;
    load_data = '0;
    flush     = 1'b0;
    hs        = valid_w && tx.tx_ready;
    if (abort) begin
      state_d = IDLE;
      phase_d = PH_ADDR;
      row_d   = '0;
      col_d   = '0;
      last_d  = '0;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          row_d   = '0;
          phase_d = PH_ADDR;
          if (TRIM != 0) begin
            state_d = SCAN;
            col_d   = COL_LAST;
          end else begin
            state_d = EMIT;
            col_d   = '0;
            last_d  = COL_LAST;
          end
        end
        SCAN: begin
          // Address cycle first, then compare the digit returned for it.
          if (phase_q == PH_ADDR) begin
            phase_d = PH_LOAD;
          end else if (rom_digit != ASCII_SP) begin
            state_d = EMIT;
            last_d  = col_q;
            col_d   = '0;
            phase_d = PH_ADDR;
          end else if (col_q == '0) begin
            state_d   = CR;
            load      = 1'b1;
            load_data = ASCII_CR;
          end else begin
            col_d   = col_q - 1'b1;
            phase_d = PH_ADDR;
          end
        end
        EMIT: begin
          unique case (phase_q)
            PH_ADDR: phase_d = PH_LOAD;
            PH_LOAD: begin
              load      = 1'b1;
              load_data = {1'b0, rom_digit};
              phase_d   = PH_WAIT;
            end
            default: if (hs) begin
              phase_d = PH_ADDR;
              if (col_q == last_q) begin
                state_d   = CR;
                load      = 1'b1;
                load_data = ASCII_CR;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          endcase
        end
        CR: if (hs) begin
          state_d   = LF;
          load      = 1'b1;
          load_data = ASCII_LF;
        end
        LF: if (hs) begin
          phase_d = PH_ADDR;
          if (row_q == ROW_LAST) begin
            state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
            if (TRIM != 0) begin
              state_d = SCAN;
              col_d   = COL_LAST;
            end else begin
              state_d = EMIT;
              col_d   = '0;
              last_d  = COL_LAST;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  text_page_streamer_tx_byte_holder u_holder (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .flush     (flush),
    .ready     (tx.tx_ready),
    .data      (data_w),
    .valid     (valid_w)
  );

  assign tx.tx_data  = data_w;
  assign tx.tx_valid = valid_w;
  assign rom_row     = row_q;
  assign rom_col     = col_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
endmodule
